// File: rtl/alu_seq.sv
// Registered, handshaked ALU with barrel shifts and an iterative shift-add multiply.
// Optional condition flags (flag_z/n/c/v) are enabled by defining ALU_SEQ_FLAGS_EN.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int HALF  = WIDTH / 2,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  localparam int          CW      = SHW + 1;
  localparam logic [CW-1:0] LAST    = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 1);

  localparam logic [3:0] OP_MOV  = 4'b0000;
  localparam logic [3:0] OP_NOT  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_PASS = 4'b1000;
  localparam logic [3:0] OP_LI   = 4'b1001;
  localparam logic [3:0] OP_LUI  = 4'b1010;
  localparam logic [3:0] OP_LWI  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_SLL  = 4'b1101;
  localparam logic [3:0] OP_SRL  = 4'b1110;
  localparam logic [3:0] OP_SRA  = 4'b1111;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   sh;
  logic             accept;
`ifdef ALU_SEQ_FLAGS_EN
  logic             cf;
  logic             vf;
`endif

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    res  = '0;
    sh   = B[SHW-1:0];
    sum  = {1'b0, A} + {1'b0, B};
    diff = {1'b0, A} - {1'b0, B};
`ifdef ALU_SEQ_FLAGS_EN
    cf   = 1'b0;
    vf   = 1'b0;
`endif
    case (ALUOp)
      OP_MOV:  res = A;
      OP_NOT:  res = ~A;
      OP_ADD: begin
        res = sum[WIDTH-1:0];
`ifdef ALU_SEQ_FLAGS_EN
        cf  = sum[WIDTH];
        vf  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
`endif
      end
      OP_SUB: begin
        res = diff[WIDTH-1:0];
`ifdef ALU_SEQ_FLAGS_EN
        // No borrow out of the extended subtraction means A >= B unsigned.
        cf  = ~diff[WIDTH];
        vf  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
`endif
      end
      OP_OR:   res = A | B;
      OP_AND:  res = A & B;
      OP_XOR:  res = A ^ B;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_PASS: res = A;
      OP_LI:   res = {A[WIDTH-1:HALF], B[HALF-1:0]};
      OP_LUI:  res = {B[HALF-1:0], A[HALF-1:0]};
      OP_LWI:  res = B;
      OP_SLL:  res = A << sh;
      OP_SRL:  res = A >> sh;
      OP_SRA:  res = WIDTH'($signed(A) >>> sh);
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      C         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (ALUOp == OP_MUL) begin
              mcand  <= A;
              mplier <= B;
              acc    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= MUL;
            end else begin
              C         <= res;
              out_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
              flag_z    <= (res == '0);
              flag_n    <= res[WIDTH-1];
              flag_c    <= cf;
              flag_v    <= vf;
`endif
            end
          end
        end
        MUL: begin
          if (cnt != LAST) begin
            if (mplier[0])
              acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            // busy drops with the last iteration; the result loads one edge later.
            if (cnt == LAST_M1)
              busy <= 1'b0;
          end else begin
            C         <= acc;
            out_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            flag_z    <= (acc == '0);
            flag_n    <= acc[WIDTH-1];
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
`endif
            state     <= out_ready ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results are queued at issue and popped when the DUT
// hands a result over; directed checks cover reset, latency, backpressure and reset mid-multiply.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   ALUOp = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] C;
  logic         busy;
`ifdef ALU_SEQ_FLAGS_EN
  logic         flag_z, flag_n, flag_c, flag_v;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]   f;
    logic [W-1:0] c;
  } exp_t;
  exp_t q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
    .C(C),
`ifdef ALU_SEQ_FLAGS_EN
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a transfer happens at the edge after a negedge with out_valid && out_ready.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", {31'b0, out_valid}, '0);
      end else begin
        e = q.pop_front();
        check("C", C, e.c);
`ifdef ALU_SEQ_FLAGS_EN
        check("flags_zncv", {28'b0, flag_z, flag_n, flag_c, flag_v}, {28'b0, e.f});
`endif
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ec, input logic [3:0] ef, input bit push);
    int n = 0;
    ALUOp = op; A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready)
      check("accept_timeout", {31'b0, in_ready}, 1);
    if (push)
      q.push_back({ef, ec});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  initial begin
    int lat, nbusy, nready, n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_C", C, '0);
    check("reset_out_valid", {31'b0, out_valid}, '0);
    check("reset_busy", {31'b0, busy}, '0);
    check("reset_in_ready", {31'b0, in_ready}, 1);

    // Flags encoded as {z,n,c,v}.
    issue(4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1010, 1);
    check("add_latency_out_valid", {31'b0, out_valid}, 1);
    issue(4'b0011, 32'h5,         32'h7,         32'hFFFF_FFFE, 4'b0100, 1);
    issue(4'b0011, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0011, 1);
    issue(4'b0011, 32'h0,         32'h0,         32'h0,         4'b1010, 1);
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0101, 1);
    issue(4'b0111, 32'hFFFF_FFFE, 32'h1,         32'h1,         4'b0000, 1);
    issue(4'b0111, 32'h1,         32'hFFFF_FFFE, 32'h0,         4'b1000, 1);
    issue(4'b1111, 32'h8000_0000, 32'h4,         32'hF800_0000, 4'b0100, 1);
    issue(4'b1110, 32'h8000_0000, 32'h21,        32'h4000_0000, 4'b0000, 1);
    issue(4'b1101, 32'h1234_5678, 32'h0,         32'h1234_5678, 4'b0000, 1);
    issue(4'b1101, 32'h1,         32'hFFFF_FFFF, 32'h8000_0000, 4'b0100, 1);
    issue(4'b1001, 32'hAAAA_5555, 32'h1234_BEEF, 32'hAAAA_BEEF, 4'b0100, 1);
    issue(4'b1010, 32'hAAAA_5555, 32'h1234_BEEF, 32'hBEEF_5555, 4'b0100, 1);
    issue(4'b1011, 32'hAAAA_5555, 32'h1234_BEEF, 32'h1234_BEEF, 4'b0000, 1);
    issue(4'b1000, 32'hAAAA_5555, 32'h1234_BEEF, 32'hAAAA_5555, 4'b0100, 1);
    issue(4'b0000, 32'h0,         32'h5,         32'h0,         4'b1000, 1);
    issue(4'b0001, 32'h0,         32'h5,         32'hFFFF_FFFF, 4'b0100, 1);
    issue(4'b0100, 32'h0F,        32'hF0,        32'hFF,        4'b0000, 1);
    issue(4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0100, 1);
    issue(4'b0110, 32'h3C3C,      32'h3C3C,      32'h0,         4'b1000, 1);

    // Multiply: latency, busy duration and in_ready hold-off.
    issue(4'b1100, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 4'b0000, 1);
    lat = 0; nbusy = 0; nready = 0;
    if (busy) nbusy++;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
      if (busy) nbusy++;
      if (in_ready && !out_valid) nready++;
    end
    check("mul_latency", lat, 33);
    check("mul_busy_cycles", nbusy, 32);
    check("mul_in_ready_low", nready, 0);
    issue(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 4'b0000, 1);

    // Backpressure: ADD result held while a pending XOR is refused.
    repeat (40) begin
      if (q.size() != 0) @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    issue(4'b0010, 32'h2, 32'h3, 32'h5, 4'b0000, 1);
    ALUOp = 4'b0110; A = 32'hFF; B = 32'h0F; in_valid = 1'b1;
    q.push_back({4'b0000, 32'hF0});
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, '0);
      check("bp_out_valid", {31'b0, out_valid}, 1);
      check("bp_C_held", C, 32'h5);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_xor_out_valid", {31'b0, out_valid}, 1);
    check("bp_xor_C", C, 32'hF0);

    // Reset during a multiply aborts it.
    @(posedge clk);
    #1;
    issue(4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, '0, 4'b0000, 0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mul_out_valid", {31'b0, out_valid}, '0);
    check("rst_mul_busy", {31'b0, busy}, '0);
    check("rst_mul_in_ready", {31'b0, in_ready}, 1);
    repeat (40) @(posedge clk);
    #1;
    check("rst_mul_no_late_result", {31'b0, out_valid}, '0);
    issue(4'b0010, 32'h7, 32'h8, 32'hF, 4'b0000, 1);

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", q.size(), 0);
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
